cut3_bist_ctrl: RTL
===================

# cut3_bist_ctrl

Built-in self-test controller for a 3-input / 3-output combinational circuit-under-test (CUT).
- Drives the CUT primary inputs from a 3-bit maximal-length LFSR.
- Compacts the CUT primary outputs into an 8-bit MISR signature.
- Compares the final signature against a golden value and reports pass/fail.
- Sits between the test-access logic (start/abort) and the CUT pins.

## Interface
Parameters:
- SEED, 3'b001, LFSR seed; a zero value is replaced by 3'b001.
- NPAT, 7, number of LFSR patterns applied; legal range 1..255.
- GOLDEN, 8'h00, expected final MISR signature.
- POLY, 8'h1D, MISR feedback polynomial taps.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request; sampled in IDLE and DONE only.
- abort  in  1  returns to IDLE from any state; higher priority than start.
- cut_po  in  3  CUT outputs; cut_po[2] is the MSB.
- cut_pi  out  3  CUT inputs; cut_pi[2] is the MSB.
- busy  out  1  high in RUN, ZERO and CMP.
- done  out  1  high in DONE.
- pass  out  1  registered compare result; valid while done=1.
- signature  out  8  live MISR contents.

## Operation
- States: IDLE, RUN, ZERO (macro only), CMP, DONE.
- Reset values: state=IDLE, lfsr=SEED, cnt=0, misr=0, pass=0, done=0, busy=0, cut_pi=0.
- LFSR step (Fibonacci, x^3+x^2+1): next = {lfsr[1:0], lfsr[2]^lfsr[1]}.
  - Sequence from 001: 001,010,101,011,111,110,100, then repeats.
- cut_pi:
  - RUN: cut_pi = lfsr.
  - ZERO: cut_pi = 3'b000.
  - All other states: cut_pi = 3'b000.
- MISR update, in RUN and ZERO at every edge: misr <= ({misr[6:0],1'b0} ^ (misr[7] ? POLY : 8'h00)) ^ {5'b0, cut_po}.
- IDLE/DONE + start:
  - state -> RUN.
  - lfsr = SEED, cnt = 0, misr = 0, pass = 0.
  - Restart from DONE follows the same path.
- RUN: each edge absorbs cut_po, advances the LFSR and increments cnt.
  - When cnt == NPAT-1 at the edge, go to CMP (or ZERO when the macro is defined).
- ZERO: applies 3'b000 for one cycle, absorbs cut_po, then goes to CMP.
- CMP: one cycle; pass <= (misr == GOLDEN); then go to DONE.
- DONE: holds signature and pass until start, abort or reset.
- abort, any state: state -> IDLE; misr and pass are cleared; lfsr is reloaded with SEED.
- start while busy is ignored.
- Simultaneous start and abort: abort wins.
- rst_n low on any edge, including mid-RUN: all outputs return to reset values at that edge.
- NPAT=1: exactly one pattern (SEED) is applied.
- NPAT > 7: the LFSR wraps, so patterns repeat with period 7.

## Timing
- start sampled at edge E:
  - cut_pi = SEED from E until E+1.
  - Pattern i is presented in cycle E+i and absorbed at edge E+i+1.
  - Last absorb at edge E+NPAT; CMP occupies the following cycle.
  - done=1 and pass valid from edge E+NPAT+1 (E+NPAT+2 with the macro).
- The CUT is combinational: cut_po must settle within the same cycle as cut_pi. No additional latency is tolerated.
- busy rises at edge E and falls at the same edge on which done rises.

## Configuration
- BIST_ZERO_PAT_EN:
  - Defined: ZERO state is compiled in. The all-zero pattern, which an LFSR never produces, is applied after the LFSR patterns. Total patterns = NPAT+1; done is one cycle later.
  - Undefined: RUN goes directly to CMP; exactly NPAT patterns are applied.

## Test plan
- Reset, then idle with start=0 for 10 cycles -> cut_pi=000, busy=0, done=0, pass=0, signature=8'h00 throughout.
- NPAT=7, macro off, start -> cut_pi over cycles = 001,010,101,011,111,110,100.
  - busy high for 8 cycles; done rises 8 edges after start; cut_pi=000 afterwards.
- cut_po tied to 3'b001, NPAT=7, GOLDEN=8'h7F, macro off, start -> signature ends at 8'h7F; pass=1.
  - Repeat with GOLDEN=8'h7E -> pass=0.
- Macro on, cut_po tied to 001 -> eighth pattern is 000 and signature = 8'hFF.
  - Repeat with cut_po tied to 000 -> signature = 8'h00 and pass=1 when GOLDEN=8'h00.
- abort asserted on the 3rd RUN cycle, with start on the same edge -> state IDLE, signature=00, busy=0, done=0.
  - A subsequent start replays from SEED.
- rst_n pulled low mid-RUN, then start issued from DONE -> outputs at reset values; the restarted run produces the same signature as the first run.

Source files
------------

// File: rtl/cut3_bist_ctrl.sv
// BIST controller for a 3-in/3-out combinational CUT: LFSR stimulus, MISR compaction.
// Optional BIST_ZERO_PAT_EN appends the all-zero pattern after the LFSR sweep.
module cut3_bist_ctrl #(
    parameter logic [2:0] SEED   = 3'b001,
    parameter int         NPAT   = 7,
    parameter logic [7:0] GOLDEN = 8'h00,
    parameter logic [7:0] POLY   = 8'h1D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] cut_po,
    output logic [2:0] cut_pi,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] signature
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_ZERO = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // An all-zero seed would lock the LFSR, so it is replaced
    localparam logic [2:0] SEED_EFF = (SEED == 3'b000) ? 3'b001 : SEED;
    localparam logic [7:0] LAST     = 8'(NPAT - 1);

`ifdef BIST_ZERO_PAT_EN
    localparam logic [2:0] S_AFTER = S_ZERO;
`else
    localparam logic [2:0] S_AFTER = S_CMP;
`endif

    logic [2:0] state;
    logic [2:0] lfsr;
    logic [7:0] cnt;
    logic [7:0] misr;
    logic       pass_q;
    logic [7:0] misr_nxt;
    logic [2:0] lfsr_nxt;

    assign misr_nxt = ({misr[6:0], 1'b0} ^ (misr[7] ? POLY : 8'h00))
                    ^ {5'b0, cut_po};
    assign lfsr_nxt = {lfsr[1:0], lfsr[2] ^ lfsr[1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            lfsr   <= SEED_EFF;
            cnt    <= 8'd0;
            misr   <= 8'd0;
            pass_q <= 1'b0;
        end else if (abort) begin
            state  <= S_IDLE;
            lfsr   <= SEED_EFF;
            cnt    <= 8'd0;
            misr   <= 8'd0;
            pass_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state  <= S_RUN;
                        lfsr   <= SEED_EFF;
                        cnt    <= 8'd0;
                        misr   <= 8'd0;
                        pass_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    misr <= misr_nxt;
                    lfsr <= lfsr_nxt;
                    cnt  <= cnt + 8'd1;
                    if (cnt == LAST) state <= S_AFTER;
                end
`ifdef BIST_ZERO_PAT_EN
                S_ZERO: begin
                    misr  <= misr_nxt;
                    state <= S_CMP;
                end
`endif
                S_CMP: begin
                    pass_q <= (misr == GOLDEN);
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cut_pi    = (state == S_RUN) ? lfsr : 3'b000;
    assign busy      = (state == S_RUN) || (state == S_ZERO)
                    || (state == S_CMP);
    assign done      = (state == S_DONE);
    assign pass      = pass_q;
    assign signature = misr;

endmodule
